// File: rtl/bist_mem_target.sv
// Single-port memory responder for the BIST control engine: req/ack access,
// fixed-latency pipelined reads, periodic refresh stalls and a stuck-at bit fault.
module bist_mem_target #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int RD_LAT     = 2,
  parameter int REF_PERIOD = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         wdata,
  output logic                      ack,
  output logic                      busy,
  output logic                      rvalid,
  output logic [DATA_W-1:0]         rdata,
  input  logic                      fault_en,
  input  logic [ADDR_W-1:0]         fault_addr,
  input  logic [$clog2(DATA_W)-1:0] fault_bit,
  input  logic                      fault_val
);

  localparam int               DEPTH    = 1 << ADDR_W;
  localparam int               CNT_W    = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam bit               REF_ON   = (REF_PERIOD > 0);
  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'((REF_PERIOD > 0) ? REF_PERIOD - 1 : 0);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [CNT_W-1:0]              ref_cnt_q, ref_cnt_d;
  logic                          busy_q, busy_d;
  logic                          stall_tail_q, stall_tail_d;
  logic                          ack_q, ack_d;
  logic [RD_LAT-1:0]             vld_q, vld_d;
  logic [RD_LAT-1:0][DATA_W-1:0] dat_q, dat_d;

  logic              accept;
  logic              wr_en;
  logic              rd_en;
  logic              ref_trig;
  logic              fault_hit;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    accept    = req && !busy_q;
    // No array writes while reset is held, so a reset mid-access leaves contents intact.
    wr_en     = accept && we && !rst;
    rd_en     = accept && !we;
    fault_hit = fault_en && (addr == fault_addr);

    wr_word = wdata;
    rd_word = mem_q[addr];
    if (fault_hit) begin
      wr_word[fault_bit] = fault_val;
      rd_word[fault_bit] = fault_val;
    end
  end

  always_comb begin
    ref_trig     = REF_ON && (ref_cnt_q == REF_LAST);
    ref_cnt_d    = '0;
    busy_d       = 1'b0;
    stall_tail_d = 1'b0;
    if (REF_ON && !ref_trig) begin
      ref_cnt_d = ref_cnt_q + 1'b1;
    end
    // The stall covers the cycle after the trigger plus one more.
    if (ref_trig) begin
      busy_d       = 1'b1;
      stall_tail_d = 1'b1;
    end else if (stall_tail_q) begin
      busy_d = 1'b1;
    end
  end

  always_comb begin
    ack_d    = accept;
    vld_d[0] = rd_en;
    dat_d[0] = rd_en ? rd_word : dat_q[0];
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= wr_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt_q    <= '0;
      busy_q       <= 1'b0;
      stall_tail_q <= 1'b0;
      ack_q        <= 1'b0;
      vld_q        <= '0;
      dat_q        <= '0;
    end else begin
      ref_cnt_q    <= ref_cnt_d;
      busy_q       <= busy_d;
      stall_tail_q <= stall_tail_d;
      ack_q        <= ack_d;
      vld_q        <= vld_d;
      dat_q        <= dat_d;
    end
  end

  // Last pipeline stage is the output register; its data only moves on a valid, so rdata holds.
  assign ack    = ack_q;
  assign busy   = busy_q;
  assign rvalid = vld_q[RD_LAT-1];
  assign rdata  = dat_q[RD_LAT-1];

endmodule

// File: tb/tb_bist_mem_target.sv
// Directed bench for bist_mem_target: vector table on a no-refresh instance plus
// hand sequences for back-to-back, pipelined, refresh-stall and mid-operation reset.
module tb_bist_mem_target;

  localparam int RD0 = 2;
  localparam int RD1 = 2;
  localparam int RD2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst  = 1'b1;
  logic rst2 = 1'b0;

  logic       req0 = 1'b0, we0 = 1'b0, fe0 = 1'b0, fv0 = 1'b0;
  logic [3:0] addr0 = '0, fa0 = '0;
  logic [2:0] fb0 = '0;
  logic [7:0] wdata0 = '0;
  logic       ack0, busy0, rv0;
  logic [7:0] rd0;

  logic       req1 = 1'b0, we1 = 1'b0;
  logic [3:0] addr1 = '0;
  logic [7:0] wdata1 = '0;
  logic       ack1, busy1, rv1;
  logic [7:0] rd1;

  logic       req2 = 1'b0, we2 = 1'b0;
  logic [3:0] addr2 = '0;
  logic [7:0] wdata2 = '0;
  logic       ack2, busy2, rv2;
  logic [7:0] rd2;

  bist_mem_target #(.ADDR_W(4), .DATA_W(8), .RD_LAT(RD0), .REF_PERIOD(0)) u0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .ack(ack0), .busy(busy0), .rvalid(rv0), .rdata(rd0),
    .fault_en(fe0), .fault_addr(fa0), .fault_bit(fb0), .fault_val(fv0));

  bist_mem_target #(.ADDR_W(4), .DATA_W(8), .RD_LAT(RD1), .REF_PERIOD(8)) u1 (
    .clk(clk), .rst(rst), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .ack(ack1), .busy(busy1), .rvalid(rv1), .rdata(rd1),
    .fault_en(1'b0), .fault_addr(4'd0), .fault_bit(3'd0), .fault_val(1'b0));

  bist_mem_target #(.ADDR_W(4), .DATA_W(8), .RD_LAT(RD2), .REF_PERIOD(0)) u2 (
    .clk(clk), .rst(rst | rst2), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .ack(ack2), .busy(busy2), .rvalid(rv2), .rdata(rd2),
    .fault_en(1'b0), .fault_addr(4'd0), .fault_bit(3'd0), .fault_val(1'b0));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Edges since reset release, used to predict the REF_PERIOD=8 stall schedule.
  int edge_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  function automatic logic exp_busy1(input int k);
    return (k >= 8) && (((k % 8) == 0) || ((k % 8) == 1));
  endfunction

  typedef struct {
    logic       we;
    logic [3:0] a;
    logic [7:0] d;
    logic       fe;
    logic [3:0] fa;
    logic [2:0] fb;
    logic       fv;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic txn0(input vec_t v, input int idx);
    req0 = 1'b1; we0 = v.we; addr0 = v.a; wdata0 = v.d;
    fe0 = v.fe; fa0 = v.fa; fb0 = v.fb; fv0 = v.fv;
    @(posedge clk); @(negedge clk);
    chk($sformatf("vec%0d ack", idx), 32'(ack0), 32'(1));
    req0 = 1'b0;
    for (int k = 1; k <= RD0 + 1; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 2) chk($sformatf("vec%0d ack drop", idx), 32'(ack0), 32'(0));
      chk($sformatf("vec%0d rvalid", idx), 32'(rv0), 32'(!v.we && (k == RD0)));
      if (!v.we && (k == RD0)) chk($sformatf("vec%0d rdata", idx), 32'(rd0), 32'(v.exp));
    end
  endtask

  task automatic wr2(input logic [3:0] a, input logic [7:0] d);
    req2 = 1'b1; we2 = 1'b1; addr2 = a; wdata2 = d;
    @(posedge clk); @(negedge clk);
    chk("u2 wr ack", 32'(ack2), 32'(1));
    req2 = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd2_chk(input logic [3:0] a, input logic [7:0] e);
    req2 = 1'b1; we2 = 1'b0; addr2 = a;
    @(posedge clk); @(negedge clk);
    chk("u2 rd ack", 32'(ack2), 32'(1));
    req2 = 1'b0;
    for (int k = 1; k <= RD2 + 1; k++) begin
      if (k > 1) @(negedge clk);
      chk("u2 rvalid", 32'(rv2), 32'(k == RD2));
      if (k == RD2) chk("u2 rdata", 32'(rd2), 32'(e));
    end
  endtask

  logic e_rv;
  logic acc;
  logic pending;
  int   rv_cd;
  int   rv_cnt;
  int   guard;

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t reached, expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 4'd5,  8'h00, 1'b1, 4'd5,  3'd0, 1'b1, 8'h00};
    vecs[1]  = '{1'b1, 4'd6,  8'h00, 1'b1, 4'd5,  3'd0, 1'b1, 8'h00};
    vecs[2]  = '{1'b0, 4'd5,  8'h00, 1'b1, 4'd5,  3'd0, 1'b1, 8'h01};
    vecs[3]  = '{1'b0, 4'd6,  8'h00, 1'b1, 4'd5,  3'd0, 1'b1, 8'h00};
    vecs[4]  = '{1'b1, 4'd7,  8'hF0, 1'b0, 4'd0,  3'd0, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 4'd7,  8'h00, 1'b1, 4'd7,  3'd7, 1'b0, 8'h70};
    vecs[6]  = '{1'b0, 4'd7,  8'h00, 1'b0, 4'd7,  3'd7, 1'b0, 8'hF0};
    vecs[7]  = '{1'b1, 4'd9,  8'h3C, 1'b1, 4'd9,  3'd2, 1'b0, 8'h00};
    vecs[8]  = '{1'b0, 4'd9,  8'h00, 1'b0, 4'd0,  3'd0, 1'b0, 8'h38};
    vecs[9]  = '{1'b0, 4'd5,  8'h00, 1'b0, 4'd0,  3'd0, 1'b0, 8'h01};
    vecs[10] = '{1'b1, 4'd0,  8'hFF, 1'b1, 4'd0,  3'd7, 1'b0, 8'h00};
    vecs[11] = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  3'd0, 1'b0, 8'h7F};
    vecs[12] = '{1'b1, 4'd15, 8'h00, 1'b0, 4'd0,  3'd0, 1'b0, 8'h00};
    vecs[13] = '{1'b0, 4'd15, 8'h00, 1'b1, 4'd15, 3'd7, 1'b1, 8'h80};
    vecs[14] = '{1'b0, 4'd6,  8'h00, 1'b1, 4'd5,  3'd1, 1'b1, 8'h00};

    // Reset / idle
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle ack0", 32'(ack0), 32'(0));
    chk("idle busy1", 32'(busy1), 32'(0));
    chk("idle rvalid2", 32'(rv2), 32'(0));
    @(posedge clk); @(negedge clk);
    chk("idle ack", 32'(ack0), 32'(0));
    chk("idle busy", 32'(busy0), 32'(0));
    chk("idle rvalid", 32'(rv0), 32'(0));
    chk("idle rdata", 32'(rd0), 32'(0));

    // Seed u1 before its first refresh stall
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'd2; wdata1 = 8'h5A;
    @(posedge clk); @(negedge clk);
    chk("u1 seed ack", 32'(ack1), 32'(1));
    req1 = 1'b0;

    // Write then read back-to-back
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 8'hA5; fe0 = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("raw ack1", 32'(ack0), 32'(1));
    we0 = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("raw ack2", 32'(ack0), 32'(1));
    chk("raw rvalid early", 32'(rv0), 32'(0));
    req0 = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("raw rvalid", 32'(rv0), 32'(1));
    chk("raw rdata", 32'(rd0), 32'(8'hA5));
    chk("raw ack idle", 32'(ack0), 32'(0));
    @(posedge clk); @(negedge clk);
    chk("raw rvalid drop", 32'(rv0), 32'(0));
    chk("raw rdata hold", 32'(rd0), 32'(8'hA5));

    // Vector table
    for (int i = 0; i < 15; i++) txn0(vecs[i], i);
    fe0 = 1'b0;

    // 16 writes then 16 back-to-back reads
    rv_cnt = 0;
    for (int n = 0; n <= 34 + RD0; n++) begin
      if (n >= 1) begin
        chk("pipe ack", 32'(ack0), 32'((n - 1) < 32));
        chk("pipe busy", 32'(busy0), 32'(0));
        e_rv = ((n - RD0) >= 16) && ((n - RD0) < 32);
        chk("pipe rvalid", 32'(rv0), 32'(e_rv));
        if (e_rv) chk("pipe rdata", 32'(rd0), 32'((n - RD0 - 16) * 17));
        if (rv0) rv_cnt++;
      end
      if (n < 32) begin
        req0 = 1'b1; we0 = (n < 16); addr0 = 4'(n % 16); wdata0 = 8'((n % 16) * 17);
      end else begin
        req0 = 1'b0;
      end
      @(posedge clk); @(negedge clk);
    end
    chk("pipe rvalid count", 32'(rv_cnt), 32'(16));

    // Refresh stall: hold a read from the first busy cycle
    guard = 0;
    while (!((edge_cnt >= 8) && ((edge_cnt % 8) == 0)) && guard < 32) begin
      @(negedge clk);
      guard++;
    end
    chk("ref stall found", 32'(guard < 32), 32'(1));
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd2;
    pending = 1'b1;
    rv_cd = -1;
    for (int n = 0; n < 24; n++) begin
      chk("ref busy", 32'(busy1), 32'(exp_busy1(edge_cnt)));
      acc = pending && !exp_busy1(edge_cnt);
      @(posedge clk); @(negedge clk);
      if (acc) begin
        pending = 1'b0;
        req1 = 1'b0;
        rv_cd = RD1 - 1;
      end else if (rv_cd >= 0) begin
        rv_cd--;
      end
      chk("ref ack", 32'(ack1), 32'(acc));
      chk("ref rvalid", 32'(rv1), 32'(rv_cd == 0));
      if (rv_cd == 0) chk("ref rdata", 32'(rd1), 32'(8'h5A));
    end
    chk("ref accepted", 32'(pending), 32'(0));

    // Mid-operation reset on the RD_LAT=4 instance
    wr2(4'd4, 8'h3C);
    rd2_chk(4'd4, 8'h3C);
    req2 = 1'b1; we2 = 1'b0; addr2 = 4'd4;
    @(posedge clk); @(negedge clk);
    chk("mr ack", 32'(ack2), 32'(1));
    req2 = 1'b0;
    @(posedge clk); @(negedge clk);
    rst2 = 1'b1;
    #1;
    chk("mr rvalid in rst", 32'(rv2), 32'(0));
    chk("mr rdata in rst", 32'(rd2), 32'(0));
    chk("mr busy in rst", 32'(busy2), 32'(0));
    repeat (2) @(negedge clk);
    rst2 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("mr no rvalid", 32'(rv2), 32'(0));
      chk("mr rdata zero", 32'(rd2), 32'(0));
      chk("mr no ack", 32'(ack2), 32'(0));
    end
    rd2_chk(4'd4, 8'h3C);
    wr2(4'd11, 8'hC3);
    rd2_chk(4'd11, 8'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bist_mem_target.md
# bist_mem_target

Single-port memory responder for the BIST `control` engine. `control` issues requests and checks data; this block services them. It accepts read and write requests over a req/ack handshake and returns read data after a fixed pipelined latency. It inserts periodic refresh stalls so the controller's wait logic is exercised, and it can inject a single stuck-at bit fault so the controller's `status` fail path can be tested.

## Interface
Parameters:
- `ADDR_W`, 4: address width; depth = 2^ADDR_W words.
- `DATA_W`, 8: word width.
- `RD_LAT`, 2: read latency in cycles, legal range 1..4.
- `REF_PERIOD`, 64: cycles between refresh stalls; 0 disables refresh.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  1  request valid.
- `we`  in  1  1 = write, 0 = read; qualified by `req`.
- `addr`  in  ADDR_W  word address.
- `wdata`  in  DATA_W  write data.
- `ack`  out  1  one-cycle pulse confirming an accepted request.
- `busy`  out  1  refresh stall; requests are not accepted while high.
- `rvalid`  out  1  one-cycle pulse; `rdata` is valid.
- `rdata`  out  DATA_W  read data; holds its last value between pulses.
- `fault_en`  in  1  enables the stuck-at fault.
- `fault_addr`  in  ADDR_W  address of the faulty word.
- `fault_bit`  in  $clog2(DATA_W)  index of the faulty bit.
- `fault_val`  in  1  stuck value of the faulty bit.

## Operation
- Accept condition: `req`=1 and `busy`=0 at a rising edge (edge T). When `busy`=1, `req` is ignored; the initiator holds `req`, `we`, `addr` and `wdata` until `ack`.
- Back-to-back requests: one request per cycle can be accepted. There is no limit on outstanding reads beyond the pipeline depth.
- Write: the array word is updated at edge T.
  - If `fault_en`=1 and `addr`==`fault_addr`, bit `fault_bit` is stored as `fault_val`.
- Read: the array is read at edge T, and the result travels through an RD_LAT-deep valid/data pipeline.
  - Same fault override is applied at read time. A fault enabled after a write still corrupts reads.
- Read-after-write to the same address on consecutive cycles returns the new data; there is no bypass hazard.
- Array contents are not cleared by `rst`. They are undefined until written.
- Refresh:
  - A counter increments every cycle and is not affected by requests.
  - When it reaches REF_PERIOD-1, `busy` is high for the next 2 cycles and the counter restarts at 0.
  - Reads already in the pipeline complete normally during `busy`.
- Fault inputs are quasi-static. They are sampled combinationally at edge T of each access.
- Reset, asynchronous and taking effect mid-operation: `ack`=0, `rvalid`=0, `rdata`=0, `busy`=0, refresh counter=0, read pipeline flushed. In-flight reads are dropped with no `rvalid`.

## Timing
- `ack` is registered: high for exactly the cycle following edge T.
- `rvalid` and `rdata` are registered: `rvalid` is high for the single cycle beginning RD_LAT edges after T.
  - For RD_LAT=1, `rvalid` coincides with `ack`.
  - Reads return in issue order.
- Writes produce `ack` only, never `rvalid`.
- `busy` is registered.
  - A request presented on the edge where `busy` rises is accepted only if `busy` was 0 at that edge.
  - The first possible accept after a stall is the edge at which `busy` has returned to 0.
- With REF_PERIOD=0, `busy` is constant 0.
- All outputs are 0 from `rst` assertion until the first edge after release.

## Test plan
- Reset/idle: assert `rst` for 10 cycles, then release with `req`=0. Required: `ack`, `busy`, `rvalid` and `rdata` are all 0.
- Write then read, RD_LAT=2, REF_PERIOD=0:
  - Write 0xA5 to address 3; next cycle read address 3.
  - Required: `ack` pulses on 2 consecutive cycles, and `rvalid` is 1 with `rdata`=0xA5 exactly 2 cycles after the read accept.
- Pipelined reads: write addresses 0..15 with value = addr×0x11, then issue 16 back-to-back reads. Required: 16 consecutive `rvalid` cycles with in-order data 0x00, 0x11, …, 0xFF.
- Refresh stall, REF_PERIOD=8:
  - Hold a read request across a stall.
  - Required: `busy` high for 2 cycles every 8, no `ack` while `busy`=1, and `ack` arrives after `busy` falls with correct data.
- Fault injection: `fault_en`=1, `fault_addr`=5, `fault_bit`=0, `fault_val`=1; write 0x00 to address 5 and to address 6, then read both. Required: address 5 reads 0x01 and address 6 reads 0x00.
- Mid-operation reset, RD_LAT=4: issue a read, then assert `rst` 2 cycles later. Required: no `rvalid` appears, `rdata`=0, and post-reset accesses behave normally.
